// File: rtl/pixel_adc_model_if.sv
// ---------------------------------------------------------------------------
// pixel_adc_model_if
// Purpose : groups the command, DAC-stimulus and result lines of one
//           pixel-plus-ADC model into a single bundle.
// Signals : erase, expose, convert, read  - readout controller commands
//           anaBias1, anaRamp             - pulse streams from the DAC model
//           data[WIDTH]                   - latched conversion code
//           dataValid                     - data holds a valid code for this read
//           cmp                           - comparator tripped in this conversion
// Modports: master - drives commands/stimulus, observes results
//           slave  - the pixel model itself
// ---------------------------------------------------------------------------
interface pixel_adc_model_if #(
   parameter int WIDTH = 8
);
   logic             erase;
   logic             expose;
   logic             convert;
   logic             read;
   logic             anaBias1;
   logic             anaRamp;
   logic [WIDTH-1:0] data;
   logic             dataValid;
   logic             cmp;

   modport master (
      output erase, expose, convert, read, anaBias1, anaRamp,
      input  data, dataValid, cmp
   );

   modport slave (
      input  erase, expose, convert, read, anaBias1, anaRamp,
      output data, dataValid, cmp
   );
endinterface

// File: rtl/pixel_adc_model.sv
// ---------------------------------------------------------------------------
// pixel_adc_model
// Purpose : behavioural pixel plus single-slope ADC. Integrates charge from
//           the anaBias1 pulse stream while exposing, then counts anaRamp
//           pulses as a digital ramp while converting and latches the ramp
//           value at which it first reaches the stored charge.
// Ports   : clk   - system clock, rising edge
//           reset - synchronous, active-high reset
//           bus   - pixel_adc_model_if.slave (commands, DAC pulses, results)
// Params  : WIDTH - width of charge, ramp counter and code
//           GAIN  - charge units added per sampled anaBias1 pulse
// ---------------------------------------------------------------------------
module pixel_adc_model #(
   parameter int WIDTH = 8,
   parameter int GAIN  = 1
) (
   input  logic                clk,
   input  logic                reset,
   pixel_adc_model_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE,
      EXPOSE,
      CONVERT,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] MAX_CODE = '1;
   localparam logic [WIDTH:0]   GAIN_EXT = (WIDTH+1)'(GAIN);

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] charge_q,    charge_d;
   logic [WIDTH-1:0] rampCnt_q,   rampCnt_d;
   logic [WIDTH-1:0] code_q,      code_d;
   logic [WIDTH-1:0] data_q,      data_d;
   logic             dataValid_q, dataValid_d;
   logic             cmp_q,       cmp_d;

   logic [WIDTH:0]   chargeSum;
   logic             tripNow;

   // Next-state and datapath decisions. Everything defaults to holding its
   // value except dataValid, which is only high while a read is being served
   // in DONE. Commands are resolved erase > expose > convert > read; erase is
   // applied last so it overrides whatever the state case decided.
   // The comparator looks at the ramp value registered before this edge's
   // increment, so an empty pixel trips on the very first conversion edge.
   always_comb begin
      state_d     = state_q;
      charge_d    = charge_q;
      rampCnt_d   = rampCnt_q;
      code_d      = code_q;
      data_d      = data_q;
      dataValid_d = 1'b0;
      cmp_d       = cmp_q;
      chargeSum   = {1'b0, charge_q} + GAIN_EXT;
      tripNow     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.expose) begin
               state_d = EXPOSE;
            end else if (bus.convert) begin
               state_d   = CONVERT;
               rampCnt_d = '0;
               cmp_d     = 1'b0;
            end
         end

         EXPOSE: begin
            if (bus.anaBias1) begin
               charge_d = chargeSum[WIDTH] ? MAX_CODE : chargeSum[WIDTH-1:0];
            end
            if (!bus.expose) begin
               state_d = IDLE;
            end
         end

         CONVERT: begin
            tripNow = !cmp_q && (rampCnt_q >= charge_q);
            if (tripNow) begin
               cmp_d  = 1'b1;
               code_d = rampCnt_q;
            end
            if (bus.anaRamp && (rampCnt_q != MAX_CODE)) begin
               rampCnt_d = rampCnt_q + WIDTH'(1);
            end
            if (!bus.convert) begin
               state_d = DONE;
               if (!cmp_q && !tripNow) begin
                  code_d = MAX_CODE;
               end
            end
         end

         DONE: begin
            if (bus.expose) begin
               state_d = EXPOSE;
            end else if (bus.convert) begin
               state_d   = CONVERT;
               rampCnt_d = '0;
               cmp_d     = 1'b0;
            end else if (bus.read) begin
               data_d      = code_q;
               dataValid_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      if (bus.erase) begin
         state_d     = IDLE;
         charge_d    = '0;
         code_d      = '0;
         cmp_d       = 1'b0;
         rampCnt_d   = '0;
         dataValid_d = 1'b0;
      end
   end

   // State and datapath registers; reset wins over every command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         charge_q    <= '0;
         rampCnt_q   <= '0;
         code_q      <= '0;
         data_q      <= '0;
         dataValid_q <= 1'b0;
         cmp_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         charge_q    <= charge_d;
         rampCnt_q   <= rampCnt_d;
         code_q      <= code_d;
         data_q      <= data_d;
         dataValid_q <= dataValid_d;
         cmp_q       <= cmp_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.dataValid = dataValid_q;
   assign bus.cmp       = cmp_q;

endmodule

// File: tb/tb_pixel_adc_model.sv
// ---------------------------------------------------------------------------
// tb_pixel_adc_model
// Purpose : self-checking bench for pixel_adc_model. Stimulus tasks drive
//           exposure/conversion/read sequences and push the expected read
//           result into a queue; a monitor pops and compares whenever the
//           DUT raises dataValid. Expected codes come from a reference model
//           built on totals and prefix sums of the pulse streams.
// ---------------------------------------------------------------------------
module tb_pixel_adc_model;

   localparam int WIDTH = 8;
   localparam int GAIN  = 4;
   localparam int MAXV  = (1 << WIDTH) - 1;

   typedef struct {
      int data;
      int cmp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   int   assertCount = 0;
   int   failCount   = 0;
   exp_t expQ[$];

   int   modelCharge;
   int   modelCode;
   int   modelCmp;

   pixel_adc_model_if #(.WIDTH(WIDTH)) bus ();

   pixel_adc_model #(
      .WIDTH (WIDTH),
      .GAIN  (GAIN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs at the falling edge and returns just after
   // the rising edge that sampled them, so callers can check the result.
   task automatic applyStimulus(input bit er, input bit ex, input bit cv,
                                input bit rd, input bit b, input bit r);
      @(negedge clk);
      bus.erase    = er;
      bus.expose   = ex;
      bus.convert  = cv;
      bus.read     = rd;
      bus.anaBias1 = b;
      bus.anaRamp  = r;
      @(posedge clk);
      #1;
   endtask

   // Erase clears the pixel: charge, code and comparator all return to zero.
   task automatic doErase();
      applyStimulus(1, 0, 0, 0, 0, 0);
      modelCharge = 0;
      modelCode   = 0;
      modelCmp    = 0;
      checkOutput("erase cmp", int'(bus.cmp), 0);
      checkOutput("erase dataValid", int'(bus.dataValid), 0);
   endtask

   // Exposure window of 'cycles' sampled cycles. Charge grows by GAIN per
   // sampled bias pulse and clips at full scale.
   task automatic runExpose(input int cycles, input bit allBias, input bit withConvert);
      int units;
      bit b;
      units = 0;
      applyStimulus(0, 1, withConvert, 0, 0, 0);
      for (int i = 0; i < cycles; i++) begin
         b = allBias ? 1'b1 : bit'($urandom_range(0, 1));
         applyStimulus(0, 1, 0, 0, b, 0);
         if (b) units++;
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      modelCharge = modelCharge + GAIN * units;
      if (modelCharge > MAXV) modelCharge = MAXV;
   endtask

   // Conversion with 'steps' driven cycles plus the exit edge. The ramp seen
   // at conversion edge i is the number of ramp pulses on earlier edges
   // (clipped); the code is that value at the first edge where it reaches the
   // charge, or full scale if it never does.
   task automatic runConvert(input int steps, input bit randomRamp, input bit finish);
      bit r[];
      int ramp;
      int tripIdx;
      r = new[steps + 1];
      for (int i = 0; i < steps; i++) begin
         r[i] = randomRamp ? bit'($urandom_range(0, 1)) : 1'b1;
      end
      r[steps] = 1'b0;
      ramp    = 0;
      tripIdx = -1;
      for (int i = 0; i <= steps; i++) begin
         if (tripIdx < 0 && ramp >= modelCharge) begin
            tripIdx   = i;
            modelCode = ramp;
         end
         ramp = (ramp + int'(r[i]) > MAXV) ? MAXV : ramp + int'(r[i]);
      end

      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("cmp cleared on entry", int'(bus.cmp), 0);
      for (int i = 0; i < steps; i++) begin
         applyStimulus(0, 0, 1, 0, 0, r[i]);
         checkOutput("cmp during convert", int'(bus.cmp),
                     (tripIdx >= 0 && i >= tripIdx) ? 1 : 0);
      end
      if (finish) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         if (tripIdx < 0) begin
            modelCode = MAXV;
            modelCmp  = 0;
         end else begin
            modelCmp  = 1;
         end
         checkOutput("cmp after convert", int'(bus.cmp), modelCmp);
      end
   endtask

   // Read from DONE, holding read for 'hold' cycles. The monitor compares the
   // code; here we check latency, hold and the one-cycle drop of dataValid.
   task automatic runRead(input int hold);
      exp_t e;
      applyStimulus(0, 0, 0, 1, 0, 0);
      e.data = modelCode;
      e.cmp  = modelCmp;
      expQ.push_back(e);
      checkOutput("read latency dataValid", int'(bus.dataValid), 1);
      for (int i = 1; i < hold; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0);
         checkOutput("dataValid hold", int'(bus.dataValid), 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("dataValid drop", int'(bus.dataValid), 0);
      checkOutput("data held after read", int'(bus.data), modelCode);
   endtask

   // A read outside DONE must never raise dataValid.
   task automatic readIgnored();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0);
         checkOutput("read ignored", int'(bus.dataValid), 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: on every rising of dataValid, pop the oldest expected result.
   initial begin : monitor
      exp_t e;
      bit   prevValid;
      prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.dataValid === 1'b1 && !prevValid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected dataValid", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("read data", int'(bus.data), e.data);
               checkOutput("read cmp", int'(bus.cmp), e.cmp);
            end
         end
         prevValid = (bus.dataValid === 1'b1);
      end
   end

   // Main sequence: directed corner cases plus randomized sessions.
   initial begin : stimulus
      bus.erase    = 1'b0;
      bus.expose   = 1'b0;
      bus.convert  = 1'b0;
      bus.read     = 1'b0;
      bus.anaBias1 = 1'b0;
      bus.anaRamp  = 1'b0;
      reset        = 1'b1;
      modelCharge  = 0;
      modelCode    = 0;
      modelCmp     = 0;

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("reset data", int'(bus.data), 0);
      checkOutput("reset dataValid", int'(bus.dataValid), 0);
      checkOutput("reset cmp", int'(bus.cmp), 0);
      reset = 1'b0;
      readIgnored();

      // Plain accumulation: 10 bias units, full-rate ramp.
      doErase();
      runExpose(10, 1'b1, 1'b0);
      runConvert(60, 1'b0, 1'b1);
      runRead(2);

      // Randomized sessions; odd ones skip erase so charge builds from DONE,
      // and the first one raises expose and convert together.
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) doErase();
         runExpose($urandom_range(5, 40), 1'b0, (k == 0));
         runConvert($urandom_range(20, 200), 1'b1, 1'b1);
         runRead($urandom_range(1, 3));
         if (k == 1) begin
            runConvert($urandom_range(100, 300), 1'b1, 1'b1);
            runRead(1);
         end
      end

      // Saturation: 100 units of GAIN clip at full scale, long ramp trips at 255.
      doErase();
      runExpose(100, 1'b1, 1'b0);
      runConvert(300, 1'b0, 1'b1);
      runRead(1);

      // Overrange: charge 200, only 50 ramp steps.
      doErase();
      runExpose(50, 1'b1, 1'b0);
      runConvert(50, 1'b0, 1'b1);
      runRead(1);

      // Empty pixel trips on the first conversion edge.
      doErase();
      readIgnored();
      runConvert(5, 1'b0, 1'b1);
      runRead(1);

      // Erase after the trip, mid-conversion.
      doErase();
      runExpose(3, 1'b1, 1'b0);
      runConvert(20, 1'b0, 1'b0);
      doErase();
      readIgnored();
      runConvert(3, 1'b0, 1'b1);
      runRead(1);

      // Reset mid-conversion after a nonzero code was read out.
      doErase();
      runExpose(5, 1'b1, 1'b0);
      runConvert(30, 1'b0, 1'b1);
      runRead(1);
      runConvert(30, 1'b0, 1'b0);
      reset = 1'b1;
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput("mid-convert reset data", int'(bus.data), 0);
      checkOutput("mid-convert reset dataValid", int'(bus.dataValid), 0);
      checkOutput("mid-convert reset cmp", int'(bus.cmp), 0);
      reset       = 1'b0;
      modelCharge = 0;
      modelCode   = 0;
      modelCmp    = 0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      runConvert(2, 1'b0, 1'b1);
      runRead(1);

      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/pixel_adc_model.md
Name: pixel_adc_model

Overview:
- Behavioural pixel-plus-ADC model: the receiving end of the DAC stimulus lines.
- Integrates charge from the anaBias1 pulse stream during exposure.
- During conversion, counts the anaRamp pulse stream as a digital ramp, trips its comparator when the ramp reaches the stored charge, and latches the code.
- Sits in the pixel array behind the DAC model; the readout controller drives erase/expose/convert/read.

Parameters:
- WIDTH, 8, bit width of charge accumulator, ramp counter and output code.
- GAIN, 1, charge units added per sampled anaBias1 high (1..2^WIDTH-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- erase  input  1  clear stored charge and code.
- expose  input  1  exposure phase enable.
- convert  input  1  conversion phase enable.
- read  input  1  request latched code.
- anaBias1  input  1  exposure pulse stream from DAC.
- anaRamp  input  1  ramp pulse stream from DAC.
- data  output  WIDTH  latched conversion code.
- dataValid  output  1  data holds a valid code for this read.
- cmp  output  1  comparator tripped in the current conversion.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; charge=0, rampCnt=0, code=0; data=0, dataValid=0, cmp=0. Reset dominates every other input, including mid-exposure and mid-conversion.
- Sampling: a "bias unit" is any rising clk edge at which anaBias1==1 while in EXPOSE. A "ramp step" is any rising clk edge at which anaRamp==1 while in CONVERT.
- States: IDLE, EXPOSE, CONVERT, DONE.
- Command priority each cycle: erase > expose > convert > read.
- erase (any state): next state IDLE; charge=0, code=0, cmp=0, rampCnt=0, dataValid=0. Takes 1 cycle.
- IDLE:
  - expose=1 -> EXPOSE.
  - convert=1 -> CONVERT, with rampCnt=0 and cmp=0.
- EXPOSE:
  - Each bias unit adds GAIN: charge = min(charge+GAIN, 2^WIDTH-1). Saturating, no wrap.
  - expose=0 -> IDLE; charge is retained.
  - Re-entering EXPOSE without erase accumulates on top of the existing charge.
- CONVERT:
  - Comparison uses the registered rampCnt before increment: if cmp==0 and rampCnt>=charge, then cmp=1 and code=rampCnt, in the same edge.
  - charge==0 therefore trips on the first CONVERT cycle with code=0.
  - Each ramp step increments rampCnt, saturating at 2^WIDTH-1.
  - After the trip, code is frozen; rampCnt keeps counting (debug only).
  - convert=0 -> DONE. If cmp==0 at exit, code=2^WIDTH-1 (overrange) and cmp stays 0.
- DONE:
  - read=1: data=code, dataValid=1 on the next edge. Both hold while read=1; dataValid drops 1 cycle after read falls, and data holds its last value.
  - expose=1 -> EXPOSE.
  - convert=1 -> CONVERT, restarting rampCnt and cmp; charge is retained.
- read in any state other than DONE is ignored; dataValid stays 0.
- expose and convert both high: expose wins (priority rule).
- Charge is never modified outside EXPOSE, except by erase and reset.
- Latency: command-to-state change is 1 cycle; read-to-dataValid is 1 cycle.

Test Plan:
- Reset with all inputs 0 -> data=0, dataValid=0, cmp=0, state IDLE. Assert reset mid-CONVERT -> all outputs 0 on the next edge.
- Exposure accumulation: erase; expose for 10 bias units, GAIN=1; convert with anaRamp high every cycle for 20 cycles; convert=0; read -> cmp=1, data=10, dataValid=1 one cycle after read.
- Saturation, WIDTH=8, GAIN=4: 100 bias units -> charge=255. Convert for 300 ramp steps -> data=255, cmp=1.
- Overrange: charge=200; convert for only 50 ramp steps -> cmp=0, data=255 after read.
- Zero charge: erase then convert -> cmp=1 on the first CONVERT edge, data=0. A read issued in IDLE before this -> dataValid stays 0.
- Priority and erase: expose and convert asserted together from IDLE -> EXPOSE entered. Assert erase during CONVERT after the trip -> charge=0, cmp=0, dataValid=0, state IDLE next cycle.
